// File: rtl/coin_refund_dispenser.sv
// coin_refund_dispenser: returns latched credit one coin at a time via hopper.
// Define REFUND_RETRY_EN to re-pulse once before declaring a hopper fault.
module coin_refund_dispenser #(
  parameter int CREDIT_W     = 3,
  parameter int PULSE_CYCLES = 4,
  parameter int GAP_CYCLES   = 4,
  parameter int ACK_TIMEOUT  = 15
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CREDIT_W-1:0] credit_in,
  input  logic                refund_req,
  input  logic                hopper_ack,
  input  logic                fault_clr,
  output logic                eject,
  output logic                credit_clr,
  output logic [CREDIT_W-1:0] coins_left,
  output logic                busy,
  output logic                done,
  output logic                fault
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_EJECT,
    S_WAIT,
    S_GAP,
    S_DONE,
    S_FAULT
  } state_t;

  localparam logic [7:0] PULSE_END = 8'(PULSE_CYCLES - 1);
  localparam logic [7:0] GAP_END   = 8'(GAP_CYCLES - 1);
  localparam logic [7:0] ACK_END   = 8'(ACK_TIMEOUT - 1);

  state_t     state;
  logic       req_q;
  logic [7:0] cnt;
  logic       req_rise;
  logic       last_coin;

`ifdef REFUND_RETRY_EN
  logic       retried;
`endif

  assign req_rise  = refund_req & ~req_q;
  assign last_coin = (coins_left <= CREDIT_W'(1));

  // Outputs follow the state one clock later; credit_clr tracks the latch.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      req_q      <= 1'b0;
      cnt        <= '0;
      coins_left <= '0;
      eject      <= 1'b0;
      credit_clr <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      fault      <= 1'b0;
`ifdef REFUND_RETRY_EN
      retried    <= 1'b0;
`endif
    end else begin
      req_q      <= refund_req;
      credit_clr <= 1'b0;
      eject      <= (state == S_EJECT);
      busy       <= (state != S_IDLE) && (state != S_FAULT);
      done       <= (state == S_DONE);
      fault      <= (state == S_FAULT);
      unique case (state)
        S_IDLE: begin
          if (req_rise) begin
            cnt <= '0;
            if (credit_in == '0) begin
              state <= S_DONE;
            end else begin
              coins_left <= credit_in;
              credit_clr <= 1'b1;
              state      <= S_EJECT;
`ifdef REFUND_RETRY_EN
              retried    <= 1'b0;
`endif
            end
          end
        end
        S_EJECT: begin
          if (cnt == PULSE_END) begin
            cnt   <= '0;
            state <= S_WAIT;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        S_WAIT: begin
          // An ack on the final allowed cycle still counts the coin.
          if (hopper_ack) begin
            cnt   <= '0;
            state <= last_coin ? S_DONE : S_GAP;
            if (coins_left != '0)
              coins_left <= coins_left - CREDIT_W'(1);
`ifdef REFUND_RETRY_EN
            retried <= 1'b0;
`endif
          end else if (cnt == ACK_END) begin
            cnt <= '0;
`ifdef REFUND_RETRY_EN
            if (!retried) begin
              retried <= 1'b1;
              state   <= S_EJECT;
            end else begin
              state <= S_FAULT;
            end
`else
            state <= S_FAULT;
`endif
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        S_GAP: begin
          if (cnt == GAP_END) begin
            cnt   <= '0;
            state <= S_EJECT;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        S_DONE: state <= S_IDLE;
        S_FAULT: begin
          if (fault_clr)
            state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_coin_refund_dispenser.sv
// tb_coin_refund_dispenser: randomized hopper responder against timing rules.
// Expected cycles come from pulse/gap/timeout arithmetic and a coin tally.
module tb_coin_refund_dispenser;

  localparam int W = 3;
  localparam int P = 4;
  localparam int G = 4;
  localparam int T = 15;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] credit_in = '0;
  logic         refund_req = 1'b0;
  logic         hopper_ack = 1'b0;
  logic         fault_clr = 1'b0;
  logic         eject, credit_clr, busy, done, fault;
  logic [W-1:0] coins_left;

  int n_checks = 0;
  int n_fail = 0;

  int n_eject, bad_width, n_clr, clr_wide, n_done, gap_err, cl_err;
  int first_rise, second_rise, first_fall, last_fall, last_ack;
  int done_cyc, fault_cyc, busy_after;
  bit timed_out;

  always #5 clk = ~clk;

  coin_refund_dispenser #(
    .CREDIT_W(W), .PULSE_CYCLES(P), .GAP_CYCLES(G), .ACK_TIMEOUT(T)
  ) dut (
    .clk(clk), .rst_n(rst_n), .credit_in(credit_in),
    .refund_req(refund_req), .hopper_ack(hopper_ack),
    .fault_clr(fault_clr), .eject(eject), .credit_clr(credit_clr),
    .coins_left(coins_left), .busy(busy), .done(done), .fault(fault)
  );

  // mode 0: one-cycle ack d cycles after eject falls; 1: ack held; 2: none
  task automatic run_refund(input int n, input int mode, input int dmin,
                            input int dmax, input bit chg, input int stop_ej);
    int w, ack_at, rem;
    bit pej, pclr, fin;
    n_eject = 0; bad_width = 0; n_clr = 0; clr_wide = 0; n_done = 0;
    gap_err = 0; cl_err = 0; first_rise = -1; second_rise = -1;
    first_fall = -1; last_fall = -1; last_ack = -1000;
    done_cyc = -1; fault_cyc = -1; busy_after = -1; timed_out = 0;
    rem = n; ack_at = -1; w = 0; pej = 0; pclr = 0; fin = 0;
    credit_in = W'(n);
    refund_req = 1'b1;
    hopper_ack = (mode == 1);
    for (int k = 1; k <= 600; k++) begin
      @(negedge clk);
      if (eject && !pej) begin
        n_eject++;
        if (n_eject == 1) first_rise = k;
        if (n_eject == 2) second_rise = k;
        if (n_eject > 1 && mode != 2 && k - last_ack != G + 2) gap_err++;
      end
      if (eject) w++;
      if (!eject && pej) begin
        if (w != P) bad_width++;
        w = 0;
        if (first_fall < 0) first_fall = k;
        last_fall = k;
        if (mode == 0) ack_at = k + int'($urandom_range(dmax, dmin));
        if (mode == 1) begin last_ack = k - 1; rem--; end
      end
      if (k == last_ack + 1 && coins_left !== W'(rem)) cl_err++;
      if (credit_clr) begin n_clr++; if (pclr) clr_wide++; end
      if (done) begin n_done++; done_cyc = k; end
      if (fault && fault_cyc < 0) fault_cyc = k;
      pej = eject; pclr = credit_clr;
      if (stop_ej > 0 && n_eject == stop_ej) return;
      if (done_cyc > 0 && k == done_cyc + 1) begin
        busy_after = int'(busy); fin = 1; break;
      end
      if (fault_cyc > 0) begin fin = 1; break; end
      if (!chg && k == 3) refund_req = 1'b0;
      if (chg && second_rise > 0 && k == second_rise + 1) refund_req = 1'b0;
      if (chg && second_rise > 0 && k == second_rise + 3) begin
        refund_req = 1'b1; credit_in = W'(1);
      end
      if (mode == 0) begin
        hopper_ack = (k == ack_at);
        if (k == ack_at) begin last_ack = k; rem--; end
      end
    end
    if (!fin) timed_out = 1;
    hopper_ack = 1'b0;
    refund_req = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({eject, credit_clr, busy, done, fault, coins_left} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs got %b want 0",
               {eject, credit_clr, busy, done, fault, coins_left});
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_basic();
    run_refund(3, 0, 2, 2, 0, 0);
    n_checks++; if (timed_out !== 1'b0) begin n_fail++; $display("FAIL basic_budget got %0d want 0", timed_out); end
    n_checks++; if (n_eject !== 3) begin n_fail++; $display("FAIL basic_ejects got %0d want 3", n_eject); end
    n_checks++; if (first_rise !== 2) begin n_fail++; $display("FAIL basic_first_eject got %0d want 2", first_rise); end
    n_checks++; if (bad_width !== 0) begin n_fail++; $display("FAIL basic_width got %0d want 0", bad_width); end
    n_checks++; if (gap_err !== 0) begin n_fail++; $display("FAIL basic_gap got %0d want 0", gap_err); end
    n_checks++; if (cl_err !== 0) begin n_fail++; $display("FAIL basic_coins_left got %0d want 0", cl_err); end
    n_checks++; if (n_clr !== 1 || clr_wide !== 0) begin n_fail++; $display("FAIL basic_credit_clr got %0d/%0d want 1/0", n_clr, clr_wide); end
    n_checks++; if (n_done !== 1 || done_cyc !== last_ack + 2) begin n_fail++; $display("FAIL basic_done got %0d@%0d want 1@%0d", n_done, done_cyc, last_ack + 2); end
    n_checks++; if (busy_after !== 0) begin n_fail++; $display("FAIL basic_busy_end got %0d want 0", busy_after); end
  endtask

  task automatic test_zero_credit();
    run_refund(0, 0, 0, 0, 0, 0);
    n_checks++; if (done_cyc !== 2 || n_done !== 1) begin n_fail++; $display("FAIL zero_done got %0d@%0d want 1@2", n_done, done_cyc); end
    n_checks++; if (n_eject !== 0 || n_clr !== 0) begin n_fail++; $display("FAIL zero_quiet got %0d/%0d want 0/0", n_eject, n_clr); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 5; i++) begin
      int n;
      n = int'($urandom_range(7, 1));
      run_refund(n, 0, 0, 6, 0, 0);
      n_checks++; if (n_eject !== n || timed_out !== 1'b0) begin n_fail++; $display("FAIL rnd_ejects got %0d want %0d", n_eject, n); end
      n_checks++; if (bad_width + gap_err + cl_err + clr_wide !== 0) begin n_fail++; $display("FAIL rnd_timing got %0d/%0d/%0d/%0d want 0", bad_width, gap_err, cl_err, clr_wide); end
      n_checks++; if (n_done !== 1 || done_cyc !== last_ack + 2 || fault_cyc !== -1) begin n_fail++; $display("FAIL rnd_done got %0d@%0d want 1@%0d", n_done, done_cyc, last_ack + 2); end
    end
  endtask

  task automatic test_timeout();
    run_refund(2, 2, 0, 0, 0, 0);
`ifdef REFUND_RETRY_EN
    n_checks++; if (n_eject !== 2 || second_rise !== first_fall + T) begin n_fail++; $display("FAIL retry_pulse got %0d@%0d want 2@%0d", n_eject, second_rise, first_fall + T); end
`else
    n_checks++; if (n_eject !== 1) begin n_fail++; $display("FAIL timeout_ejects got %0d want 1", n_eject); end
`endif
    n_checks++; if (fault_cyc !== last_fall + T) begin n_fail++; $display("FAIL timeout_cycle got %0d want %0d", fault_cyc, last_fall + T); end
    n_checks++; if (fault !== 1'b1 || busy !== 1'b0 || coins_left !== W'(2)) begin n_fail++; $display("FAIL fault_hold got %b/%b/%0d want 1/0/2", fault, busy, coins_left); end
    fault_clr = 1'b1;
    @(negedge clk);
    fault_clr = 1'b0;
    @(negedge clk);
    n_checks++; if (fault !== 1'b0 || coins_left !== W'(2)) begin n_fail++; $display("FAIL fault_clr got %b/%0d want 0/2", fault, coins_left); end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_ignore_midstream();
    run_refund(5, 0, 0, 4, 1, 0);
    n_checks++; if (n_eject !== 5) begin n_fail++; $display("FAIL mid_ejects got %0d want 5", n_eject); end
    n_checks++; if (n_done !== 1 || n_clr !== 1) begin n_fail++; $display("FAIL mid_pulses got %0d/%0d want 1/1", n_done, n_clr); end
  endtask

  task automatic test_reset_mid();
    run_refund(4, 0, 1, 3, 0, 2);
    rst_n = 1'b0;
    hopper_ack = 1'b0;
    refund_req = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({eject, busy, done, fault, coins_left} !== '0) begin
      n_fail++;
      $display("FAIL reset_mid got %b want 0", {eject, busy, done, fault, coins_left});
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    run_refund(1, 0, 0, 3, 0, 0);
    n_checks++; if (n_eject !== 1 || n_done !== 1) begin n_fail++; $display("FAIL reset_resume got %0d/%0d want 1/1", n_eject, n_done); end
  endtask

  task automatic test_ack_edges();
    int n;
    n = int'($urandom_range(5, 2));
    run_refund(n, 1, 0, 0, 0, 0);
    n_checks++; if (n_eject !== n || cl_err !== 0) begin n_fail++; $display("FAIL held_ack got %0d/%0d want %0d/0", n_eject, cl_err, n); end
    n_checks++;
    if (last_ack - first_rise + 2 !== n * (P + 1) + (n - 1) * G) begin
      n_fail++;
      $display("FAIL held_span got %0d want %0d", last_ack - first_rise + 2, n * (P + 1) + (n - 1) * G);
    end
    run_refund(2, 0, T - 2, T - 2, 0, 0);
    n_checks++; if (fault_cyc !== -1 || n_eject !== 2 || n_done !== 1) begin n_fail++; $display("FAIL edge_ack got %0d/%0d want -1/2", fault_cyc, n_eject); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_credit();
    test_random();
    test_timeout();
    test_ignore_midstream();
    test_reset_mid();
    test_ack_edges();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
